// File: rtl/datapath_sequencer_if.sv
// Instruction handshake plus datapath control bundle for datapath_sequencer.
// Latency: none, this is wiring only.
// Backpressure: instr_ready is driven by the sequencer and qualifies instr_valid.
interface datapath_sequencer_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  signalBits;
    logic [4:0]  readA;
    logic [4:0]  readB;
    logic [4:0]  writeReg;
    logic [4:0]  functionsel;
    logic        ALUcarry;
    logic        write;
    logic        RAMwrite;
    logic        muxSelect;
    logic        busy;

    // Instruction source / datapath side
    modport master (
        output instr, instr_valid, signalBits,
        input  instr_ready, readA, readB, writeReg, functionsel,
        input  ALUcarry, write, RAMwrite, muxSelect, busy
    );

    // Sequencer side
    modport slave (
        input  instr, instr_valid, signalBits,
        output instr_ready, readA, readB, writeReg, functionsel,
        output ALUcarry, write, RAMwrite, muxSelect, busy
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: decodes one instruction and steps EXEC/MEM/WB driving datapath controls.
// Latency: ALU 3, STORE 3, LOAD 4, SKIP 2, dropped 2 cycles from acceptance to next instr_ready.
// Backpressure: instr_ready high only in IDLE; all outputs registered (Moore). Macro: CTRL_FLAGS_EN.
module datapath_sequencer #(
    parameter logic [4:0] IDLE_FUNC   = 5'd0,
    parameter bit         ZERO_REG_WE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    datapath_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_DROP} state_t;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] mask;
        logic       use_carry;
        logic [1:0] kind;
        logic [4:0] func;
        logic [4:0] rb;
        logic [4:0] ra;
        logic [4:0] rd;
    } instr_t;

    localparam logic [1:0] K_ALU   = 2'b00;
    localparam logic [1:0] K_STORE = 2'b01;
    localparam logic [1:0] K_LOAD  = 2'b10;
    localparam logic [1:0] K_SKIP  = 2'b11;

    state_t     state_q, state_d;
    instr_t     fld_q, fld_d;
    logic       skip_q, skip_d;

    logic       rdy_q, rdy_d, busy_q, busy_d;
    logic [4:0] ra_q, ra_d, rb_q, rb_d, wr_q, wr_d, fn_q, fn_d;
    logic       carry_q, carry_d, we_q, we_d, ram_q, ram_d, mux_q, mux_d;

`ifdef CTRL_FLAGS_EN
    // flags are {N,Z,C,V}; C sits at bit 1
    logic [3:0] flags_q, flags_d;
`else
    logic       unused_sig;
    assign unused_sig = ^bus.signalBits;
`endif

    // Next-state: sequencing, field capture, flag capture and skip bookkeeping
    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        skip_d  = skip_q;
`ifdef CTRL_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && rdy_q) begin
                    fld_d   = instr_t'(bus.instr);
                    state_d = skip_q ? S_DROP : S_EXEC;
                end
            end
            S_EXEC: begin
                case (fld_q.kind)
                    K_ALU: begin
                        state_d = S_WB;
`ifdef CTRL_FLAGS_EN
                        flags_d = bus.signalBits;
`endif
                    end
                    K_STORE, K_LOAD: state_d = S_MEM;
                    default: begin
                        state_d = S_IDLE;
`ifdef CTRL_FLAGS_EN
                        if ((flags_q & fld_q.mask) != 4'd0) skip_d = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM:   state_d = (fld_q.kind == K_LOAD) ? S_WB : S_IDLE;
            S_WB:    state_d = S_IDLE;
            S_DROP: begin
                skip_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state being entered, so every control is a flop
    always_comb begin
        rdy_d   = 1'b0;
        busy_d  = 1'b1;
        ra_d    = 5'd0;
        rb_d    = 5'd0;
        wr_d    = 5'd0;
        fn_d    = IDLE_FUNC;
        carry_d = 1'b0;
        we_d    = 1'b0;
        ram_d   = 1'b0;
        mux_d   = 1'b0;
        case (state_d)
            S_IDLE: begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
            end
            S_EXEC: begin
                ra_d = fld_d.ra;
                rb_d = fld_d.rb;
                fn_d = fld_d.func;
`ifdef CTRL_FLAGS_EN
                carry_d = fld_d.use_carry & flags_d[1];
`endif
            end
            S_MEM: begin
                ra_d  = fld_d.ra;
                rb_d  = fld_d.rb;
                fn_d  = fld_d.func;
                ram_d = (fld_d.kind == K_STORE);
            end
            S_WB: begin
                wr_d  = fld_d.rd;
                we_d  = ZERO_REG_WE || (fld_d.rd != 5'd0);
                mux_d = (fld_d.kind == K_LOAD);
            end
            default: ;
        endcase
    end

    // Sequencer state; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            fld_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            skip_q  <= skip_d;
        end
    end

`ifdef CTRL_FLAGS_EN
    // ALU status capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags_q <= 4'd0;
        else      flags_q <= flags_d;
    end
`endif

    // Registered controls; instr_ready stays low for the whole reset window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            ra_q    <= 5'd0;
            rb_q    <= 5'd0;
            wr_q    <= 5'd0;
            fn_q    <= IDLE_FUNC;
            carry_q <= 1'b0;
            we_q    <= 1'b0;
            ram_q   <= 1'b0;
            mux_q   <= 1'b0;
        end else begin
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wr_q    <= wr_d;
            fn_q    <= fn_d;
            carry_q <= carry_d;
            we_q    <= we_d;
            ram_q   <= ram_d;
            mux_q   <= mux_d;
        end
    end

    assign bus.instr_ready = rdy_q;
    assign bus.busy        = busy_q;
    assign bus.readA       = ra_q;
    assign bus.readB       = rb_q;
    assign bus.writeReg    = wr_q;
    assign bus.functionsel = fn_q;
    assign bus.ALUcarry    = carry_q;
    assign bus.write       = we_q;
    assign bus.RAMwrite    = ram_q;
    assign bus.muxSelect   = mux_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed instruction stream, trace-queue model, literal pins.
// Latency: model predicts every output cycle from acceptance onwards.
// Backpressure: driver holds instr_valid until instr_ready is seen.
module tb_datapath_sequencer;

    localparam logic [4:0] TB_IDLE_FUNC = 5'd17;
`ifdef CTRL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic       rdy;
        logic       busy;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] wr;
        logic [4:0] fn;
        logic       carry;
        logic       we;
        logic       ram;
        logic       mux;
    } ov_t;

    logic clk;
    logic rst;
    logic chk_en;
    int   n_checks;
    int   n_fail;

    ov_t        exp_q[$];
    logic [3:0] m_flags;
    logic       m_skip;

    datapath_sequencer_if bus();

    datapath_sequencer #(.IDLE_FUNC(TB_IDLE_FUNC), .ZERO_REG_WE(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ov_t sample();
        ov_t v;
        v.rdy = bus.instr_ready;  v.busy = bus.busy;
        v.ra = bus.readA;         v.rb = bus.readB;
        v.wr = bus.writeReg;      v.fn = bus.functionsel;
        v.carry = bus.ALUcarry;   v.we = bus.write;
        v.ram = bus.RAMwrite;     v.mux = bus.muxSelect;
        return v;
    endfunction

    function automatic ov_t reset_v();
        ov_t v = '0;
        v.fn = TB_IDLE_FUNC;
        return v;
    endfunction

    function automatic ov_t idle_v();
        ov_t v = reset_v();
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic ov_t busy_v();
        ov_t v = reset_v();
        v.busy = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [4:0] fn, input logic uc,
                                       input logic [3:0] mask);
        return {5'b10110, mask, uc, kind, fn, rb, ra, rd};
    endfunction

    // Expand one accepted instruction into the list of busy cycles it must produce
    function automatic void model_accept(input logic [31:0] ins, input logic [3:0] sig);
        logic [4:0] rd, ra, rb, fn;
        logic [1:0] kind;
        logic       uc;
        logic [3:0] mask;
        ov_t ex, mem, wb;
        rd = ins[4:0];   ra = ins[9:5];  rb = ins[14:10]; fn = ins[19:15];
        kind = ins[21:20]; uc = ins[22]; mask = ins[26:23];
        if (m_skip) begin
            exp_q.push_back(busy_v());
            m_skip = 1'b0;
            return;
        end
        ex = busy_v();
        ex.ra = ra; ex.rb = rb; ex.fn = fn;
        ex.carry = FLAGS && uc && m_flags[1];
        mem = busy_v();
        mem.ra = ra; mem.rb = rb; mem.fn = fn;
        mem.ram = (kind == 2'b01);
        wb = busy_v();
        wb.wr = rd; wb.we = (rd != 5'd0); wb.mux = (kind == 2'b10);
        exp_q.push_back(ex);
        case (kind)
            2'b00: begin
                exp_q.push_back(wb);
                if (FLAGS) m_flags = sig;
            end
            2'b01: exp_q.push_back(mem);
            2'b10: begin
                exp_q.push_back(mem);
                exp_q.push_back(wb);
            end
            default: if (FLAGS && ((m_flags & mask) != 4'd0)) m_skip = 1'b1;
        endcase
    endfunction

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic lit_vec(input string name, input ov_t act, input ov_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Per-cycle compare against the model trace, then feed acceptances into the model
    initial begin
        ov_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                m_flags = 4'd0;
                m_skip  = 1'b0;
            end else if (chk_en) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_v();
                lit_vec("cycle_cmp", sample(), e);
                if (bus.instr_valid && bus.instr_ready) model_accept(bus.instr, bus.signalBits);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance
    task automatic issue(input logic [31:0] ins, input logic [3:0] sig, output int waited);
        waited = 0;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.instr_ready) lit("issue_timeout", 32'd0, 32'd1);
        bus.signalBits = sig;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr = $urandom;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        n_checks = 0; n_fail = 0; chk_en = 1'b0;
        bus.instr = 32'd0; bus.instr_valid = 1'b0; bus.signalBits = 4'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 lit_vec("reset_outputs", sample(), reset_v());
        repeat (2) @(posedge clk);
        #1 lit_vec("reset_held", sample(), reset_v());
        #1 rst = 1'b1;
        step();
        lit("ready_after_reset", bus.instr_ready, 1);
        chk_en = 1'b1;

        // ALU ra=3 rb=4 rd=5 func=2, plus an unaccepted valid pulse while busy
        issue(mk(2'b00, 5'd5, 5'd3, 5'd4, 5'd2, 1'b0, 4'd0), 4'd0, w);
        lit("alu_exec_readA", bus.readA, 3);
        lit("alu_exec_readB", bus.readB, 4);
        lit("alu_exec_func", bus.functionsel, 2);
        bus.instr = mk(2'b10, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 4'd0);
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        lit("alu_wb_write", bus.write, 1);
        lit("alu_wb_reg", bus.writeReg, 5);
        lit("alu_wb_mux", bus.muxSelect, 0);
        lit("alu_wb_ready", bus.instr_ready, 0);
        step();
        lit("alu_ready_cycle3", bus.instr_ready, 1);

        // LOAD rd=7 then STORE back-to-back
        issue(mk(2'b10, 5'd7, 5'd1, 5'd2, 5'd6, 1'b0, 4'd0), 4'd0, w);
        step(); step();
        lit("load_wb_write", bus.write, 1);
        lit("load_wb_mux", bus.muxSelect, 1);
        lit("load_wb_reg", bus.writeReg, 7);
        issue(mk(2'b01, 5'd0, 5'd7, 5'd8, 5'd3, 1'b0, 4'd0), 4'd0, w);
        lit("store_accept_cycle4", w, 1);
        step();
        lit("store_mem_ram", bus.RAMwrite, 1);
        lit("store_mem_write", bus.write, 0);
        step();

        // Z captured, SKIP on Z, next instruction dropped, then normal ALU
        issue(mk(2'b00, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 4'd0), 4'b0100, w);
        issue(mk(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0100), 4'd0, w);
        issue(mk(2'b00, 5'd9, 5'd5, 5'd6, 5'd7, 1'b0, 4'd0), 4'd0, w);
        lit("drop_busy", bus.busy, 1);
        lit("drop_readA", bus.readA, FLAGS ? 0 : 5);
        step();
        lit("drop_write", bus.write, FLAGS ? 0 : 1);
        lit("drop_ready", bus.instr_ready, FLAGS ? 1 : 0);
        issue(mk(2'b00, 5'd10, 5'd1, 5'd1, 5'd5, 1'b0, 4'd0), 4'd0, w);
        step();
        lit("after_drop_write", bus.write, 1);
        lit("after_drop_reg", bus.writeReg, 10);

        // C captured, then use_carry
        issue(mk(2'b00, 5'd1, 5'd1, 5'd2, 5'd1, 1'b0, 4'd0), 4'b0010, w);
        issue(mk(2'b00, 5'd2, 5'd3, 5'd4, 5'd1, 1'b1, 4'd0), 4'd0, w);
        lit("carry_exec", bus.ALUcarry, FLAGS ? 1 : 0);

        // SKIP with mask 0 is a 2-cycle NOP
        issue(mk(2'b11, 5'd0, 5'd0, 5'd0, 5'd9, 1'b0, 4'd0), 4'd0, w);
        step();
        lit("nop_skip_ready", bus.instr_ready, 1);

        // rd=0: WB cycle happens with write held low
        issue(mk(2'b00, 5'd0, 5'd4, 5'd4, 5'd3, 1'b0, 4'd0), 4'd0, w);
        lit("r0_busy_c1", bus.busy, 1);
        step();
        lit("r0_busy_c2", bus.busy, 1);
        lit("r0_write", bus.write, 0);
        step();
        lit("r0_busy_c3", bus.busy, 0);

        // Reset during LOAD writeback
        issue(mk(2'b10, 5'd7, 5'd2, 5'd3, 5'd8, 1'b0, 4'd0), 4'd0, w);
        step(); step();
        lit("pre_reset_write", bus.write, 1);
        chk_en = 1'b0;
        #1 rst = 1'b0;
        #1 lit_vec("mid_load_reset", sample(), reset_v());
        step();
        lit_vec("mid_load_reset_held", sample(), reset_v());
        #1 rst = 1'b1;
        step();
        lit("ready_after_mid_reset", bus.instr_ready, 1);
        chk_en = 1'b1;

        issue(mk(2'b00, 5'd3, 5'd6, 5'd7, 5'd2, 1'b1, 4'd0), 4'd0, w);
        lit("post_reset_carry", bus.ALUcarry, 0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
